// File: rtl/pkg_arbitro.sv
// Shared definitions for the two-source round-robin arbiter feeding the 2:1 mux datapath.
package pkg_arbitro;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } state_t;

endpackage

// File: rtl/mux2x1.sv
// One-bit 2:1 multiplexer; sel = 0 passes a, sel = 1 passes b.
module mux2x1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/arbitro_mux2.sv
// Two-source round-robin arbiter with burst limit, driving a bit-sliced 2:1 mux
// and a single-entry registered output stage.
module arbitro_mux2
  import pkg_arbitro::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  state_t           last_r;
  state_t           last_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;
  logic             out_valid_r;
  logic             out_valid_nxt;
  logic             out_src_r;
  logic             out_src_nxt;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] out_data_nxt;
  logic [WIDTH-1:0] mux_data_s;
  logic             last_src_s;
  logic             sel_s;
  logic             load_en_s;
  logic             a_ready_s;
  logic             b_ready_s;
  logic             xfer_s;

  // Bit-sliced datapath: every slice shares the arbiter's select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux2x1 u_mux (
      .a   (a_data[i]),
      .b   (b_data[i]),
      .sel (sel_s),
      .y   (mux_data_s[i])
    );
  end

  assign last_src_s = (last_r == LAST_B) ? SRC_B : SRC_A;

  // Source choice and handshake; rst_n gating drops both readies as soon as reset asserts.
  always_comb begin
    sel_s = last_src_s;
    if (a_valid && b_valid) begin
      if (cnt_r < CNT_MAX) begin
        sel_s = last_src_s;
      end else begin
        sel_s = ~last_src_s;
      end
    end else if (a_valid) begin
      sel_s = SRC_A;
    end else if (b_valid) begin
      sel_s = SRC_B;
    end else begin
      sel_s = last_src_s;
    end
    load_en_s = rst_n & (~out_valid_r | out_ready);
    a_ready_s = load_en_s & (sel_s == SRC_A) & a_valid;
    b_ready_s = load_en_s & (sel_s == SRC_B) & b_valid;
    xfer_s    = a_ready_s | b_ready_s;
  end

  // Next-state: output stage load/drain, last-source FSM and saturating burst counter.
  always_comb begin
    last_nxt      = last_r;
    cnt_nxt       = cnt_r;
    out_valid_nxt = out_valid_r;
    out_data_nxt  = out_data_r;
    out_src_nxt   = out_src_r;
    if (xfer_s) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = mux_data_s;
      out_src_nxt   = sel_s;
      if (sel_s == last_src_s) begin
        if (cnt_r < CNT_MAX) begin
          cnt_nxt = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt = CNT_MAX;
        end
      end else begin
        cnt_nxt  = CNT_ONE;
        last_nxt = (sel_s == SRC_B) ? LAST_B : LAST_A;
      end
    end else if (load_en_s) begin
      out_valid_nxt = 1'b0;
    end else begin
      out_valid_nxt = out_valid_r;
    end
  end

  // State register; reset makes A the winner of the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r      <= LAST_B;
      cnt_r       <= CNT_MAX;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= 1'b0;
    end else begin
      last_r      <= last_nxt;
      cnt_r       <= cnt_nxt;
      out_valid_r <= out_valid_nxt;
      out_data_r  <= out_data_nxt;
      out_src_r   <= out_src_nxt;
    end
  end

  assign sel       = sel_s;
  assign a_ready   = a_ready_s;
  assign b_ready   = b_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

endmodule

// File: tb/tb_arbitro_mux2.sv
// Directed bench for arbitro_mux2: vector table for MAX_BURST=4 plus reset and MAX_BURST=1 sequences.
module tb_arbitro_mux2;

  logic       clk;
  logic       rst_n;
  logic       a_valid;
  logic [7:0] a_data;
  logic       b_valid;
  logic [7:0] b_data;
  logic       out_ready;

  logic       a_ready, b_ready, sel, out_valid, out_src;
  logic [7:0] out_data;
  logic       a_ready1, b_ready1, sel1, out_valid1, out_src1;
  logic [7:0] out_data1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ordy;
    logic       e_sel;
    logic       e_ar;
    logic       e_br;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_os;
  } vec_t;

  vec_t vecs[$];

  arbitro_mux2 #(.WIDTH(8), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  arbitro_mux2 #(.WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
    .sel(sel1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_src(out_src1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd,
                     input logic ordy, input logic e_sel, input logic e_ar, input logic e_br,
                     input logic e_ov, input logic [7:0] e_od, input logic e_os);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
    v.e_sel = e_sel; v.e_ar = e_ar; v.e_br = e_br;
    v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n     = 1'b0;
    a_valid   = 1'b1;
    a_data    = 8'h11;
    b_valid   = 1'b1;
    b_data    = 8'h21;
    out_ready = 1'b1;

    // Burst: 4 x A, 4 x B, then A; registered outputs lag grants by one cycle.
    add(1'b1, 8'h11, 1'b1, 8'h21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'h12, 1'b1, 8'h21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    add(1'b1, 8'h13, 1'b1, 8'h21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0);
    add(1'b1, 8'h14, 1'b1, 8'h21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0);
    add(1'b1, 8'h15, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h14, 1'b0);
    add(1'b1, 8'h15, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 1'b1);
    add(1'b1, 8'h15, 1'b1, 8'h23, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
    add(1'b1, 8'h15, 1'b1, 8'h24, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h23, 1'b1);
    add(1'b1, 8'h15, 1'b1, 8'h25, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h24, 1'b1);
    add(1'b1, 8'h16, 1'b1, 8'h25, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h15, 1'b0);
    // Lone source A for ten cycles with words 0x10..0x19.
    add(1'b1, 8'h10, 1'b0, 8'h25, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h16, 1'b0);
    for (int k = 1; k < 10; k++) begin
      add(1'b1, 8'h10 + 8'(k), 1'b0, 8'h25, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10 + 8'(k - 1), 1'b0);
    end
    // B arrives: A's counter is saturated, so B wins at once.
    add(1'b1, 8'h1A, 1'b1, 8'h30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h19, 1'b0);
    // Idle: sel stays on last, output stage empties but keeps data/src.
    add(1'b0, 8'h1A, 1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30, 1'b1);
    add(1'b0, 8'h1A, 1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 1'b1);
    // Back-pressure: empty stage loads, then three stalled cycles, then drain+fill.
    add(1'b1, 8'h40, 1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 1'b1);
    add(1'b1, 8'h40, 1'b1, 8'h51, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h50, 1'b1);
    add(1'b1, 8'h40, 1'b1, 8'h51, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h50, 1'b1);
    add(1'b1, 8'h40, 1'b1, 8'h51, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h50, 1'b1);
    add(1'b1, 8'h40, 1'b1, 8'h51, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h50, 1'b1);
    add(1'b0, 8'h40, 1'b0, 8'h51, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h51, 1'b1);

    // Reset held with both sources valid.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      a_valid   = vecs[i].av;
      a_data    = vecs[i].ad;
      b_valid   = vecs[i].bv;
      b_data    = vecs[i].bd;
      out_ready = vecs[i].ordy;
      rst_n     = 1'b1;
      #1;
      chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].e_ar));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].e_br));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      chk($sformatf("v%0d_out_src", i), 32'(out_src), 32'(vecs[i].e_os));
    end

    // Reset while holding 0xA5: word lost, readies drop at once, A wins afterwards.
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'hA5; b_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("a5_load_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("a5_held_valid", 32'(out_valid), 32'd1);
    chk("a5_held_data", 32'(out_data), 32'hA5);
    chk("a5_stall_a_ready", 32'(a_ready), 32'd0);
    #2 rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_a_ready", 32'(a_ready), 32'd0);
    a_data = 8'h61; b_valid = 1'b1; b_data = 8'h62;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_sel", 32'(sel), 32'd0);
    chk("postrst_a_ready", 32'(a_ready), 32'd1);
    chk("postrst_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("postrst_out_valid", 32'(out_valid), 32'd1);
    chk("postrst_out_data", 32'(out_data), 32'h61);
    chk("postrst_out_src", 32'(out_src), 32'd0);

    // MAX_BURST = 1: strict alternation starting with A.
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = 8'h71; b_valid = 1'b1; b_data = 8'h82; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("alt%0d_sel", k), 32'(sel1), 32'(k % 2));
      chk($sformatf("alt%0d_a_ready", k), 32'(a_ready1), 32'((k + 1) % 2));
      chk($sformatf("alt%0d_b_ready", k), 32'(b_ready1), 32'(k % 2));
      if (k == 0) begin
        chk("alt0_out_valid", 32'(out_valid1), 32'd0);
      end else begin
        chk($sformatf("alt%0d_out_valid", k), 32'(out_valid1), 32'd1);
        chk($sformatf("alt%0d_out_src", k), 32'(out_src1), 32'((k - 1) % 2));
        chk($sformatf("alt%0d_out_data", k), 32'(out_data1),
            ((k - 1) % 2 == 0) ? 32'h71 : 32'h82);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_mux2.md
Name: arbitro_mux2

Overview:
- Two-source round-robin arbiter with a registered output stage. Sits directly upstream of, and drives the select of, the team's 2:1 multiplexer datapath.
- Two producers (A, B) offer words over valid/ready. The block picks one source per cycle, drives `sel` to the mux, and registers the muxed word into a single-entry output stage toward the consumer.
- A burst limit prevents one source from starving the other.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_BURST, 4, maximum consecutive transfers from one source while the other is also valid (>=1; 1 = strict alternation).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- a_valid  in  1  source A offers a_data.
- a_data  in  WIDTH  source A word.
- a_ready  out  1  A's word is taken this cycle.
- b_valid  in  1  source B offers b_data.
- b_data  in  WIDTH  source B word.
- b_ready  out  1  B's word is taken this cycle.
- sel  out  1  mux select; 0 = A, 1 = B; combinational.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WIDTH  registered muxed word.
- out_src  out  1  source of out_data (0 = A, 1 = B).

Behaviour:
- State registers:
  - `last` (1b): last granted source. Reset value 1.
  - `cnt`: consecutive grants to `last`, $clog2(MAX_BURST+1) bits. Reset value MAX_BURST, so A wins the first contention.
  - `out_valid`, `out_data`, `out_src`: reset values 0.
- Choice (combinational), `sel`:
  - a_valid and b_valid both set: sel = last if cnt < MAX_BURST, else ~last.
  - Only one valid: sel = that source.
  - Neither valid: sel = last, and no grant.
- load_en = !out_valid || out_ready.
  - The output stage is never back-pressured while it is empty.
  - It accepts simultaneous drain and fill in the same cycle (full throughput).
- Grant:
  - a_ready = load_en & (sel==0) & a_valid.
  - b_ready = load_en & (sel==1) & b_valid.
  - At most one ready is high per cycle. ready never depends on the other source's data.
- Transfer (a_ready or b_ready high), next edge:
  - out_data <= muxed word; out_valid <= 1; out_src <= sel.
  - If sel == last: cnt <= min(cnt+1, MAX_BURST). Otherwise cnt <= 1 and last <= sel.
- load_en high with no transfer: out_valid <= 0. out_data and out_src hold their values.
- load_en low: every register holds. Both ready signals are 0 and out_data is stable while out_valid & !out_ready.
- Latency: 1 cycle from the handshake to out_valid. Sustained throughput is 1 word/cycle.
- FSM view: two states LAST_A / LAST_B.
  - LAST_A -> LAST_B on a transfer from B; LAST_B -> LAST_A on a transfer from A.
  - The burst counter is a saturating sub-state.
- Lone source: while only one source is valid it is served every cycle, unlimited. cnt saturates at MAX_BURST, so a contender arriving later wins immediately.
- Reset mid-operation: any word held in out_data is discarded, and `last`/`cnt` return to their reset values. ready signals go low asynchronously with rst_n.
- Sources must hold valid and data until ready. The block does not check this.

Decomposition:
- Shared package (pkg_arbitro): SRC_A = 1'b0, SRC_B = 1'b1; a state enum {LAST_A, LAST_B}; a default WIDTH constant.
- One natural sub-module: the team's existing 1-bit mux2x1, instantiated WIDTH times through a generate loop with a common `sel`. This forms the datapath ahead of the output register.

Test Plan:
- Reset with a_valid = b_valid = 1 held through deassert -> out_valid = 0, ready signals 0 during reset; first grant is A (sel = 0, a_ready = 1); next cycle out_data = a_data, out_src = 0.
- MAX_BURST = 4, both valid continuously, out_ready = 1 -> grant sequence A,A,A,A,B,B,B,B,A... (out_src stream 0000111100...), one word per cycle, no bubbles.
- Only A valid for 10 cycles (a_data = 0x10..0x19), then B raises valid -> ten A words in order, then B granted on the very next cycle.
- out_valid = 1, out_ready = 0 for 3 cycles with both sources valid -> a_ready = b_ready = 0; out_data/out_src stable. out_ready = 1 -> the held word drains and the next word loads in the same edge.
- MAX_BURST = 1, both valid -> strict alternation 0,1,0,1; cnt never exceeds 1.
- Assert rst_n low while out_valid = 1 with word 0xA5 -> out_valid = 0 immediately, word lost; after release A wins the first contention again.
